// File: rtl/hex_led_decoder.sv
// hex_led_decoder
//   Receive side of a multiplexed, active-low seven-segment display bus.
//   The segment and digit-select lines are synchronised, each digit pattern
//   is debounced, decoded back to a hex nibble and collected into a shadow
//   register. Once every digit has been seen in a frame the whole value is
//   presented at once.
//
//   Optional feature macro: HEX_LED_DECODER_DP_EN
//     When defined, seg_n is 8 bits wide. Bit 7 is the decimal point
//     (active low). It is captured per slot and presented on dp_out.
//
// Parameters
//   DIGITS         number of multiplexed digits (1..8)
//   STABLE_CYCLES  cycles a pattern must hold before capture (2..255)
//   CNT_W          stability counter width, must hold STABLE_CYCLES-1
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   seg_n        segment lines, active low, bit0=a .. bit6=g (bit7=dp)
//   dig_n        digit selects, active low, bit i = slot i
//   value        assembled value, slot i at [4i+3:4i]
//   value_valid  sticky, set by the first complete frame
//   frame_done   one-cycle pulse when value is reloaded
//   decode_err   one-cycle pulse when an unknown pattern is captured
//   dp_out       per-slot decimal points (feature build only)
module hex_led_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 8,
    parameter int CNT_W         = 8
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef HEX_LED_DECODER_DP_EN
    input  logic [7:0]            seg_n,
`else
    input  logic [6:0]            seg_n,
`endif
    input  logic [DIGITS-1:0]     dig_n,
    output logic [4*DIGITS-1:0]   value,
    output logic                  value_valid,
    output logic                  frame_done,
`ifdef HEX_LED_DECODER_DP_EN
    output logic                  decode_err,
    output logic [DIGITS-1:0]     dp_out
`else
    output logic                  decode_err
`endif
);

`ifdef HEX_LED_DECODER_DP_EN
    localparam int SEG_W = 8;
`else
    localparam int SEG_W = 7;
`endif

    localparam logic [DIGITS-1:0] SEL_ONE  = DIGITS'(1);
    // cnt counts stable cycles after the first one, so the final stable
    // cycle is the one in which cnt still reads STABLE_CYCLES-2.
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 2);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    // Exact-match decode; bit 4 of the result flags a known pattern.
    function automatic logic [4:0] decode_seg(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'h3f:   r = 5'h10;
            7'h06:   r = 5'h11;
            7'h5b:   r = 5'h12;
            7'h4f:   r = 5'h13;
            7'h66:   r = 5'h14;
            7'h6d:   r = 5'h15;
            7'h7d:   r = 5'h16;
            7'h07:   r = 5'h17;
            7'h7f:   r = 5'h18;
            7'h6f:   r = 5'h19;
            7'h77:   r = 5'h1a;
            7'h7c:   r = 5'h1b;
            7'h39:   r = 5'h1c;
            7'h5e:   r = 5'h1d;
            7'h79:   r = 5'h1e;
            7'h71:   r = 5'h1f;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    logic [SEG_W-1:0]    seg_s1_q, seg_s2_q, seg_prev_q;
    logic [DIGITS-1:0]   dig_s1_q, dig_s2_q, sel_prev_q;
    logic [SEG_W-1:0]    seg;
    logic [DIGITS-1:0]   sel;
    logic                changed, onehot, capture;
    logic [4:0]          dec;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DIGITS-1:0]   cap_q, cap_d;
    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic [4*DIGITS-1:0] value_q, value_d;
    logic                valid_q, valid_d;
    logic                frame_q, frame_d;
    logic                err_q, err_d;
`ifdef HEX_LED_DECODER_DP_EN
    logic [DIGITS-1:0]   dp_shadow_q, dp_shadow_d;
    logic [DIGITS-1:0]   dp_q, dp_d;
`endif

    assign seg     = ~seg_s2_q;
    assign sel     = ~dig_s2_q;
    assign changed = (seg != seg_prev_q) || (sel != sel_prev_q);
    assign onehot  = (sel != '0) && ((sel & (sel - SEL_ONE)) == '0);
    assign dec     = decode_seg(seg[6:0]);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (onehot) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            end
            SETTLE: begin
                if (changed) begin
                    cnt_d = '0;
                    if (!onehot) state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HOLD: begin
                if (changed) begin
                    cnt_d   = '0;
                    state_d = onehot ? SETTLE : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shadow_d = shadow_q;
        cap_d    = cap_q;
        value_d  = value_q;
        valid_d  = valid_q;
        frame_d  = 1'b0;
        err_d    = 1'b0;
`ifdef HEX_LED_DECODER_DP_EN
        dp_shadow_d = dp_shadow_q;
        dp_d        = dp_q;
`endif
        if (capture) begin
            if (dec[4]) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (sel[i]) begin
                        shadow_d[4*i +: 4] = dec[3:0];
`ifdef HEX_LED_DECODER_DP_EN
                        dp_shadow_d[i] = seg[7];
`endif
                    end
                end
                cap_d = cap_q | sel;
                // The capture that completes the set loads the shadow
                // including the nibble written on this same edge.
                if (&cap_d) begin
                    value_d = shadow_d;
                    valid_d = 1'b1;
                    frame_d = 1'b1;
                    cap_d   = '0;
`ifdef HEX_LED_DECODER_DP_EN
                    dp_d    = dp_shadow_d;
`endif
                end
            end else begin
                err_d = 1'b1;
                cap_d = cap_q & ~sel;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_s1_q   <= '1;
            seg_s2_q   <= '1;
            dig_s1_q   <= '1;
            dig_s2_q   <= '1;
            seg_prev_q <= '0;
            sel_prev_q <= '0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            cap_q      <= '0;
            shadow_q   <= '0;
            value_q    <= '0;
            valid_q    <= 1'b0;
            frame_q    <= 1'b0;
            err_q      <= 1'b0;
`ifdef HEX_LED_DECODER_DP_EN
            dp_shadow_q <= '0;
            dp_q        <= '0;
`endif
        end else begin
            seg_s1_q   <= seg_n;
            seg_s2_q   <= seg_s1_q;
            dig_s1_q   <= dig_n;
            dig_s2_q   <= dig_s1_q;
            seg_prev_q <= seg;
            sel_prev_q <= sel;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cap_q      <= cap_d;
            shadow_q   <= shadow_d;
            value_q    <= value_d;
            valid_q    <= valid_d;
            frame_q    <= frame_d;
            err_q      <= err_d;
`ifdef HEX_LED_DECODER_DP_EN
            dp_shadow_q <= dp_shadow_d;
            dp_q        <= dp_d;
`endif
        end
    end

    assign value       = value_q;
    assign value_valid = valid_q;
    assign frame_done  = frame_q;
    assign decode_err  = err_q;
`ifdef HEX_LED_DECODER_DP_EN
    assign dp_out      = dp_q;
`endif

endmodule

// File: tb/tb_hex_led_decoder.sv
// Testbench for hex_led_decoder: directed scans plus random scanning,
// checked every cycle against a run-length based behavioural model.
module tb_hex_led_decoder;

    localparam int DIGITS = 4;
    localparam int STABLE = 8;
`ifdef HEX_LED_DECODER_DP_EN
    localparam int SEG_W = 8;
`else
    localparam int SEG_W = 7;
`endif

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [SEG_W-1:0]      seg_n = '1;
    logic [DIGITS-1:0]     dig_n = '1;
    logic [4*DIGITS-1:0]   value;
    logic                  value_valid, frame_done, decode_err;
`ifdef HEX_LED_DECODER_DP_EN
    logic [DIGITS-1:0]     dp_out;
`endif

    int checks = 0;
    int errors = 0;
    int frames = 0;
    int errs   = 0;

    hex_led_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .seg_n(seg_n), .dig_n(dig_n),
        .value(value), .value_valid(value_valid),
`ifdef HEX_LED_DECODER_DP_EN
        .dp_out(dp_out),
`endif
        .frame_done(frame_done), .decode_err(decode_err)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
                                 7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: the DUT sees pins two edges late; a one-hot
    // pattern is captured on the cycle its unchanged run reaches STABLE.
    logic [SEG_W-1:0]    m_p1_seg, m_p2_seg, m_prev_seg;
    logic [DIGITS-1:0]   m_p1_dig, m_p2_dig, m_prev_dig;
    int                  m_run;
    logic [3:0]          m_shadow [DIGITS];
    logic [DIGITS-1:0]   m_dp_sh, m_dp, m_cap;
    logic [4*DIGITS-1:0] m_value;
    logic                m_valid, m_frame, m_err;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_p1_seg = '1; m_p2_seg = '1; m_prev_seg = '1;
            m_p1_dig = '1; m_p2_dig = '1; m_prev_dig = '1;
            m_run = 0;
            for (int i = 0; i < DIGITS; i++) m_shadow[i] = 4'h0;
            m_dp_sh = '0; m_dp = '0; m_cap = '0;
            m_value = '0; m_valid = 1'b0; m_frame = 1'b0; m_err = 1'b0;
        end else begin
            logic [DIGITS-1:0] sel;
            logic [6:0]        pat;
            int                slot;
            int                nib;
            m_frame = 1'b0;
            m_err   = 1'b0;
            if (m_p2_seg == m_prev_seg && m_p2_dig == m_prev_dig) begin
                if (m_run < 1000) m_run++;
            end else begin
                m_run = 1;
            end
            m_prev_seg = m_p2_seg;
            m_prev_dig = m_p2_dig;
            sel = ~m_p2_dig;
            if ($countones(sel) == 1 && m_run == STABLE) begin
                slot = 0;
                for (int i = 0; i < DIGITS; i++) if (sel[i]) slot = i;
                pat = ~m_p2_seg[6:0];
                nib = -1;
                for (int k = 0; k < 16; k++) if (seg_tab[k] == pat) nib = k;
                if (nib >= 0) begin
                    m_shadow[slot] = nib[3:0];
`ifdef HEX_LED_DECODER_DP_EN
                    m_dp_sh[slot] = ~m_p2_seg[7];
`endif
                    m_cap[slot] = 1'b1;
                    if (m_cap == '1) begin
                        for (int i = 0; i < DIGITS; i++) m_value[4*i +: 4] = m_shadow[i];
                        m_dp    = m_dp_sh;
                        m_valid = 1'b1;
                        m_frame = 1'b1;
                        m_cap   = '0;
                    end
                end else begin
                    m_err = 1'b1;
                    m_cap[slot] = 1'b0;
                end
            end
            m_p2_seg = m_p1_seg; m_p2_dig = m_p1_dig;
            m_p1_seg = seg_n;    m_p1_dig = dig_n;
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        chk("value", 64'(value), 64'(m_value));
        chk("value_valid", 64'(value_valid), 64'(m_valid));
        chk("frame_done", 64'(frame_done), 64'(m_frame));
        chk("decode_err", 64'(decode_err), 64'(m_err));
`ifdef HEX_LED_DECODER_DP_EN
        chk("dp_out", 64'(dp_out), 64'(m_dp));
`endif
        if (frame_done) frames++;
        if (decode_err) errs++;
    end

    task automatic show(input int slot, input logic [6:0] pat, input logic dp, input int cyc);
        dig_n = ~(DIGITS'(1) << slot);
`ifdef HEX_LED_DECODER_DP_EN
        seg_n = {~dp, ~pat};
`else
        seg_n = ~pat;
        if (dp) seg_n = ~pat;
`endif
        repeat (cyc) begin @(posedge clk); #2; end
    endtask

    task automatic idle(input int cyc);
        dig_n = '1;
        seg_n = '1;
        repeat (cyc) begin @(posedge clk); #2; end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("reset value", 64'(value), 64'h0);
        chk("reset valid", 64'(value_valid), 64'h0);
        reset = 1'b0;
        idle(4);

        // Scan 1,2,3,4 into slots 3..0.
        show(3, 7'h06, 1'b0, 12);
        show(2, 7'h5b, 1'b0, 12);
        show(1, 7'h4f, 1'b0, 12);
        show(0, 7'h66, 1'b0, 12);
        idle(4);
        chk("scan1 value", 64'(value), 64'h1234);
        chk("scan1 frames", 64'(frames), 64'd1);
        chk("scan1 valid", 64'(value_valid), 64'h1);

        // 7-cycle hold is too short; the following 8-cycle hold captures.
        show(0, 7'h3f, 1'b0, 7);
        show(0, 7'h7f, 1'b0, 8);
        show(1, 7'h6d, 1'b0, 12);
        show(2, 7'h7d, 1'b0, 12);
        show(3, 7'h07, 1'b0, 12);
        idle(4);
        chk("debounce value", 64'(value), 64'h7658);
        chk("debounce frames", 64'(frames), 64'd2);

        // Unknown pattern on slot 2, then repair it.
        show(3, 7'h4f, 1'b0, 12);
        show(2, 7'h00, 1'b0, 12);
        show(1, 7'h06, 1'b0, 12);
        show(0, 7'h39, 1'b0, 12);
        idle(4);
        chk("err pulses", 64'(errs), 64'd1);
        chk("err no frame", 64'(frames), 64'd2);
        show(2, 7'h77, 1'b0, 12);
        idle(4);
        chk("repair value", 64'(value), 64'h3A1C);
        chk("repair frames", 64'(frames), 64'd3);

        // Two selects active: never a capture.
        dig_n = 4'b1100;
        seg_n = '1;
        seg_n[6:0] = ~7'h3f;
        repeat (20) begin @(posedge clk); #2; end
        idle(4);
        chk("twohot frames", 64'(frames), 64'd3);
        chk("twohot errs", 64'(errs), 64'd1);
        chk("twohot value", 64'(value), 64'h3A1C);

        // Reset mid-frame discards captured slots.
        show(0, 7'h5e, 1'b0, 12);
        show(1, 7'h79, 1'b0, 12);
        show(2, 7'h71, 1'b0, 12);
        idle(4);
        reset = 1'b1;
        @(posedge clk); #2;
        chk("midreset value", 64'(value), 64'h0);
        chk("midreset valid", 64'(value_valid), 64'h0);
        reset = 1'b0;
        idle(2);
        show(0, 7'h6f, 1'b0, 12);
        show(1, 7'h7c, 1'b0, 12);
        show(2, 7'h3f, 1'b0, 12);
        idle(4);
        chk("partial no frame", 64'(frames), 64'd3);
        show(3, 7'h66, 1'b0, 12);
        idle(4);
        chk("post reset value", 64'(value), 64'h40B9);
        chk("post reset frames", 64'(frames), 64'd4);

`ifdef HEX_LED_DECODER_DP_EN
        show(3, 7'h06, 1'b0, 12);
        show(2, 7'h5b, 1'b1, 12);
        show(1, 7'h4f, 1'b0, 12);
        show(0, 7'h66, 1'b0, 12);
        idle(4);
        chk("dp value", 64'(value), 64'h1234);
        chk("dp_out", 64'(dp_out), 64'h4);
`endif

        // Random scanning, checked by the model every cycle.
        for (int n = 0; n < 250; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 85) begin
                logic [6:0] pat;
                if ($urandom_range(0, 9) < 8) pat = seg_tab[$urandom_range(0, 15)];
                else pat = 7'($urandom);
                show(int'($urandom_range(0, DIGITS-1)), pat, 1'($urandom),
                     int'($urandom_range(1, 14)));
            end else if (r < 93) begin
                dig_n = DIGITS'($urandom);
                seg_n = SEG_W'($urandom);
                repeat ($urandom_range(1, 12)) begin @(posedge clk); #2; end
            end else begin
                idle(int'($urandom_range(1, 6)));
            end
        end
        idle(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
